// File: rtl/click_pkg.sv
// Constants shared by the click classifier and its consumers.
// This file holds the event bit positions, the state encoding and the LED patterns.
package click_pkg;

    localparam int unsigned EV_SINGLE = 0;
    localparam int unsigned EV_DOUBLE = 1;
    localparam int unsigned EV_LONG   = 2;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHOW_S = 2'd1;
    localparam logic [1:0] ST_SHOW_D = 2'd2;
    localparam logic [1:0] ST_SHOW_L = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        SHOW_S = ST_SHOW_S,
        SHOW_D = ST_SHOW_D,
        SHOW_L = ST_SHOW_L
    } state_t;

    localparam logic [2:0] LED_OFF    = 3'b000;
    localparam logic [2:0] LED_SINGLE = 3'b001;
    localparam logic [2:0] LED_DOUBLE = 3'b010;
    localparam logic [2:0] LED_LONG   = 3'b100;

    // Priority long > double > single; an empty bus maps to IDLE.
    function automatic state_t event_to_state(input logic [2:0] ev);
        state_t st;
        st = IDLE;
        if (ev[EV_LONG]) begin
            st = SHOW_L;
        end else if (ev[EV_DOUBLE]) begin
            st = SHOW_D;
        end else if (ev[EV_SINGLE]) begin
            st = SHOW_S;
        end
        return st;
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond tick prescaler: emits a one-cycle pulse every CLK_HZ/1000 clocks.
// Asserting clr restarts the count so that the next tick is a full period away.
module ms_tick_gen #(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic CLOCK,
    input  logic RST_n,
    input  logic clr,
    output logic tick
);

    localparam int unsigned TICK = CLK_HZ / 1000;
    localparam int unsigned PW   = (TICK > 1) ? $clog2(TICK) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK - 1);

    logic [PW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + PW'(1);
        end
    end

    always_ff @(posedge CLOCK or negedge RST_n) begin
        if (!RST_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST) && !clr;

endmodule

// File: rtl/click_led_show_module.sv
// Turns single/double/long click events into timed LED patterns on three LEDs.
// A new event always restarts timing with its own pattern, including in the expiry cycle.
module click_led_show_module
    import click_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 50_000_000,
    parameter int unsigned HOLD_MS  = 1000,
    parameter int unsigned BLINK_MS = 100
) (
    input  logic       CLOCK,
    input  logic       RST_n,
    input  logic [2:0] Pin_In,
    output logic [2:0] LED
);

    localparam int unsigned MW = $clog2(HOLD_MS + 1);
    localparam int unsigned BW = $clog2(BLINK_MS + 1);

    localparam logic [MW-1:0] HOLD_FULL  = MW'(HOLD_MS);
    localparam logic [MW-1:0] HOLD_LAST  = MW'(HOLD_MS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_MS - 1);

    if ((CLK_HZ % 1000) != 0 || CLK_HZ < 1000) begin : g_bad_clk
        $error("CLK_HZ must be a non-zero multiple of 1000");
    end
    if (HOLD_MS < 1 || BLINK_MS < 1 || BLINK_MS > HOLD_MS) begin : g_bad_ms
        $error("need 1 <= BLINK_MS <= HOLD_MS");
    end

    state_t        state_q, state_d;
    logic [MW-1:0] ms_q, ms_d;
    logic [BW-1:0] blink_q, blink_d;
    logic          phase_q, phase_d;
    logic [2:0]    led_q, led_d;
    logic          start;
    logic          tick;

    assign start = |Pin_In;

    ms_tick_gen #(
        .CLK_HZ(CLK_HZ)
    ) u_ms_tick_gen (
        .CLOCK(CLOCK),
        .RST_n(RST_n),
        .clr  (start),
        .tick (tick)
    );

    // LED follows the state one cycle later, so an expiry edge still shows the pattern.
    always_comb begin
        led_d = LED_OFF;
        unique case (state_q)
            SHOW_S:  led_d = LED_SINGLE;
            SHOW_D:  led_d = phase_q ? LED_DOUBLE : LED_OFF;
            SHOW_L:  led_d = LED_LONG;
            default: led_d = LED_OFF;
        endcase
    end

    always_comb begin
        state_d = state_q;
        ms_d    = ms_q;
        blink_d = blink_q;
        phase_d = phase_q;
        if (start) begin
            state_d = event_to_state(Pin_In);
            ms_d    = '0;
            blink_d = '0;
            phase_d = 1'b1;
        end else if ((state_q != IDLE) && tick) begin
            if (ms_q == HOLD_LAST) begin
                ms_d    = HOLD_FULL;
                state_d = IDLE;
            end else begin
                ms_d = ms_q + MW'(1);
            end
            if (state_q == SHOW_D) begin
                if (blink_q == BLINK_LAST) begin
                    blink_d = '0;
                    phase_d = !phase_q;
                end else begin
                    blink_d = blink_q + BW'(1);
                end
            end
        end
    end

    always_ff @(posedge CLOCK or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= IDLE;
            ms_q    <= '0;
            blink_q <= '0;
            phase_q <= 1'b0;
            led_q   <= LED_OFF;
        end else begin
            state_q <= state_d;
            ms_q    <= ms_d;
            blink_q <= blink_d;
            phase_q <= phase_d;
            led_q   <= led_d;
        end
    end

    assign LED = led_q;

endmodule

// File: tb/tb_click_led_show_module.sv
// Bench for click_led_show_module: directed scenarios plus random events and resets,
// checked every cycle against an elapsed-time model of the LED patterns.
module tb_click_led_show_module;

    localparam int unsigned CLK_HZ   = 10_000;
    localparam int unsigned HOLD_MS  = 5;
    localparam int unsigned BLINK_MS = 1;
    localparam longint HT = longint'(HOLD_MS) * (CLK_HZ / 1000);
    localparam longint BT = longint'(BLINK_MS) * (CLK_HZ / 1000);

    logic       CLOCK = 1'b0;
    logic       RST_n;
    logic [2:0] Pin_In;
    logic [2:0] LED;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: active pattern (0 none, 1 single, 2 double, 3 long) and its start edge.
    int     pat      = 0;
    longint start_ed = 0;
    longint edge_cnt = 0;

    click_led_show_module #(
        .CLK_HZ  (CLK_HZ),
        .HOLD_MS (HOLD_MS),
        .BLINK_MS(BLINK_MS)
    ) dut (
        .CLOCK (CLOCK),
        .RST_n (RST_n),
        .Pin_In(Pin_In),
        .LED   (LED)
    );

    always #5 CLOCK = ~CLOCK;

    function automatic logic [2:0] led_for(input int p, input longint e);
        if (p == 0 || e < 1 || e > HT) return 3'b000;
        if (p == 1) return 3'b001;
        if (p == 3) return 3'b100;
        return ((((e - 1) / BT) % 2) == 0) ? 3'b010 : 3'b000;
    endfunction

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: LED=%b expected %b (edge %0d, t=%0t)", name, act, exp,
                     edge_cnt, $time);
        end
    endtask

    always @(negedge RST_n) pat = 0;

    always @(posedge CLOCK) begin
        logic [2:0] exp;
        edge_cnt++;
        exp = led_for(pat, edge_cnt - start_ed);
        if (!RST_n) begin
            pat = 0;
        end else if (Pin_In != 3'b000) begin
            start_ed = edge_cnt;
            if (Pin_In[2])      pat = 3;
            else if (Pin_In[1]) pat = 2;
            else                pat = 1;
        end
        #1;
        check("model", LED, exp);
    end

    task automatic adv(input int n);
        repeat (n) @(posedge CLOCK);
        #2;
    endtask

    // Event sampled at the next rising edge (edge 0); returns 2 time units after it.
    task automatic send(input logic [2:0] ev);
        @(negedge CLOCK);
        Pin_In = ev;
        adv(1);
        Pin_In = 3'b000;
    endtask

    initial begin
        RST_n  = 1'b0;
        Pin_In = 3'b000;
        repeat (3) begin
            @(negedge CLOCK);
            Pin_In = 3'($urandom);
            adv(1);
            check("reset_hold", LED, 3'b000);
        end
        @(negedge CLOCK);
        Pin_In = 3'b000;
        RST_n  = 1'b1;
        adv(3);

        send(3'b001);
        adv(1);  check("single_e1", LED, 3'b001);
        adv(49); check("single_e50", LED, 3'b001);
        adv(1);  check("single_e51", LED, 3'b000);
        adv(5);

        send(3'b010);
        adv(1);  check("double_e1", LED, 3'b010);
        adv(9);  check("double_e10", LED, 3'b010);
        adv(1);  check("double_e11", LED, 3'b000);
        adv(10); check("double_e21", LED, 3'b010);
        adv(30); check("double_e51", LED, 3'b000);
        adv(5);

        send(3'b111);
        adv(1);  check("multi_e1", LED, 3'b100);
        adv(49); check("multi_e50", LED, 3'b100);
        adv(1);  check("multi_e51", LED, 3'b000);
        adv(5);

        send(3'b001);
        adv(29);
        Pin_In = 3'b100;
        adv(1);  check("retrig_e30", LED, 3'b001);
        Pin_In = 3'b000;
        adv(1);  check("retrig_e31", LED, 3'b100);
        adv(49); check("retrig_e80", LED, 3'b100);
        adv(1);  check("retrig_e81", LED, 3'b000);
        adv(5);

        send(3'b001);
        adv(49);
        Pin_In = 3'b010;
        adv(1);  check("expiry_e50", LED, 3'b001);
        Pin_In = 3'b000;
        adv(1);  check("expiry_e51", LED, 3'b010);
        adv(60);

        send(3'b100);
        adv(25); check("rstmid_e25", LED, 3'b100);
        #1 RST_n = 1'b0;
        #1 check("rstmid_async", LED, 3'b000);
        adv(2);
        @(negedge CLOCK);
        RST_n = 1'b1;
        adv(60); check("rstmid_after", LED, 3'b000);

        repeat (3000) begin
            @(negedge CLOCK);
            Pin_In = ($urandom_range(0, 39) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            if ($urandom_range(0, 499) == 0) begin
                #1 RST_n = 1'b0;
                #2 RST_n = 1'b1;
            end
        end
        @(negedge CLOCK);
        Pin_In = 3'b000;
        adv(70);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
